// File: rtl/uart_rx_core.sv
// UART receive engine: 16x oversampled start/data/parity/stop recovery into a host holding register.
// Latency: rx -> rx_s 2 clk; holding register loads on the clk edge of the STOP vote strobe.
// No backpressure: a character completing while rx_valid is set is dropped and sets sticky overflow.
module uart_rx_core #(
  parameter int GLITCH_REJECT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       rx_read,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow,
  output logic       rx_idle
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state, state_next;
  logic       rx_meta, rx_s;
  logic [3:0] samp_cnt;
  logic [3:0] bit_idx;
  logic [3:0] nbits;
  logic       samp7, samp8;
  logic       vote, at_vote, at_wrap;
  logic       char_done;
  logic [7:0] shift_reg;
  logic [7:0] data_bits;
  logic       par_bad;
  logic       par_calc;

  // Majority of the samples at counts 7, 8 and the live sample at count 9.
  assign vote      = (samp7 & samp8) | (samp7 & rx_s) | (samp8 & rx_s);
  assign at_vote   = baud_clock && (samp_cnt == 4'd9);
  assign at_wrap   = baud_clock && (samp_cnt == 4'd15);
  assign nbits     = bit8 ? 4'd8 : 4'd7;
  // In 7-bit mode only seven shifts happen, so the character sits in the upper bits.
  assign data_bits = bit8 ? shift_reg : {1'b0, shift_reg[7:1]};
  assign par_calc  = (^data_bits) ^ vote ^ odd_n_even;
  assign rx_idle   = (state == IDLE);

  // Two-flop synchronizer for the asynchronous rx pin; idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; STOP leaves at the vote so a short stop bit can resync.
  always_comb begin
    state_next = state;
    char_done  = 1'b0;
    case (state)
      IDLE: begin
        if (baud_clock && !rx_s) state_next = START;
      end
      START: begin
        if (at_vote && vote && (GLITCH_REJECT != 0)) state_next = IDLE;
        else if (at_wrap)                            state_next = DATA;
      end
      DATA: begin
        if (at_wrap && (bit_idx == nbits)) state_next = parity_en ? PARITY : STOP;
      end
      PARITY: begin
        if (at_wrap) state_next = STOP;
      end
      STOP: begin
        if (at_vote) begin
          state_next = IDLE;
          char_done  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Oversample counter, vote samples, data shifter and parity result; all advance on strobes only.
  always_ff @(posedge clk) begin
    if (reset) begin
      samp_cnt  <= 4'd0;
      samp7     <= 1'b1;
      samp8     <= 1'b1;
      bit_idx   <= 4'd0;
      shift_reg <= 8'd0;
      par_bad   <= 1'b0;
    end else if (baud_clock) begin
      if (state == IDLE && !rx_s) samp_cnt <= 4'd0;
      else                        samp_cnt <= samp_cnt + 4'd1;
      if (samp_cnt == 4'd7) samp7 <= rx_s;
      if (samp_cnt == 4'd8) samp8 <= rx_s;
      if (samp_cnt == 4'd9) begin
        case (state)
          START: begin
            bit_idx <= 4'd0;
            par_bad <= 1'b0;
          end
          DATA: begin
            shift_reg <= {vote, shift_reg[7:1]};
            bit_idx   <= bit_idx + 4'd1;
          end
          PARITY:  par_bad <= par_calc;
          default: ;
        endcase
      end
    end
  end

  // Host holding register: load on completion unless an unread character is still held.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_data     <= 8'd0;
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overflow    <= 1'b0;
    end else if (char_done) begin
      if (!rx_valid || rx_read) begin
        rx_data     <= data_bits;
        rx_valid    <= 1'b1;
        parity_err  <= par_bad;
        framing_err <= ~vote;
        if (rx_read) overflow <= 1'b0;
      end else begin
        overflow <= 1'b1;
      end
    end else if (rx_read) begin
      rx_valid    <= 1'b0;
      parity_err  <= 1'b0;
      framing_err <= 1'b0;
      overflow    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed frames plus randomized frames against a host-register model.
// Frames are described per baud strobe slot; slot 0 is the strobe that detects the start edge.
// The host model tracks what the holding register and flags must show after each completion or read.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       baud_clock;
  logic       rx;
  logic       bit8;
  logic       parity_en;
  logic       odd_n_even;
  logic       rx_read;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_err;
  logic       framing_err;
  logic       overflow;
  logic       rx_idle;

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_data;
  logic       exp_valid, exp_pe, exp_fe, exp_ovf;

  uart_rx_core #(.GLITCH_REJECT(1)) dut (
    .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even), .rx_read(rx_read),
    .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
    .framing_err(framing_err), .overflow(overflow), .rx_idle(rx_idle)
  );

  always #5 clk = ~clk;

  // 16x strobe: one clk wide every 4 clk, edges offset from both clock edges.
  initial begin
    baud_clock = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #2 baud_clock = 1'b1;
      @(posedge clk);
      #2 baud_clock = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check8({tag, ".data"}, rx_data, exp_data);
    check1({tag, ".valid"}, rx_valid, exp_valid);
    check1({tag, ".perr"}, parity_err, exp_pe);
    check1({tag, ".ferr"}, framing_err, exp_fe);
    check1({tag, ".ovf"}, overflow, exp_ovf);
    check1({tag, ".idle"}, rx_idle, 1'b1);
  endtask

  task automatic model_reset();
    exp_data = 8'd0; exp_valid = 1'b0; exp_pe = 1'b0; exp_fe = 1'b0; exp_ovf = 1'b0;
  endtask

  task automatic model_read();
    exp_valid = 1'b0; exp_pe = 1'b0; exp_fe = 1'b0; exp_ovf = 1'b0;
  endtask

  task automatic model_complete(input logic [7:0] d, input logic pe, input logic fe, input logic rd);
    if (!exp_valid || rd) begin
      exp_data = d; exp_pe = pe; exp_fe = fe; exp_valid = 1'b1;
      if (rd) exp_ovf = 1'b0;
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  // Returns at the falling clk edge after the next strobe has been sampled.
  task automatic wait_strobe();
    @(posedge baud_clock);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_read();
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
    model_read();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic b8, input logic pen, input logic odd,
                            input logic par_flip, input logic stop_low, input logic noise,
                            input logic chk_lat, input logic rd_done, input int abort_at);
    int n, p, s;
    logic [7:0] dm;
    logic [11:0] bits;
    logic lvl;
    int nz[12];
    bit8 = b8; parity_en = pen; odd_n_even = odd;
    n  = b8 ? 8 : 7;
    p  = pen ? 1 : 0;
    dm = b8 ? d : {1'b0, d[6:0]};
    bits = '0;
    bits[0] = 1'b0;
    for (int i = 0; i < n; i++) bits[1 + i] = dm[i];
    if (pen) bits[1 + n] = (^dm) ^ odd ^ par_flip;
    bits[1 + n + p] = ~stop_low;
    s = 16 * (1 + n + p);
    for (int i = 0; i < 12; i++) nz[i] = $urandom_range(0, 2);
    wait_strobe();
    for (int j = 0; j < s + 18; j++) begin
      if (j < s) begin
        lvl = bits[j / 16];
        if (noise && (j / 16) >= 1 && (j / 16) <= n && (j % 16) == 8 + nz[j / 16]) lvl = ~lvl;
      end else if (j <= s + 10) begin
        lvl = bits[1 + n + p];
      end else begin
        lvl = 1'b1;
      end
      rx = lvl;
      if (j == s + 10) begin
        // Completion strobe: rx_valid must rise on exactly this strobe's clk edge.
        @(posedge baud_clock);
        if (rd_done) rx_read = 1'b1;
        #1;
        if (chk_lat) check1("latency.before", rx_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rx_read = 1'b0;
        if (chk_lat) check1("latency.after", rx_valid, 1'b1);
        model_complete(dm, pen & par_flip, stop_low, rd_done);
      end else begin
        wait_strobe();
      end
      if (j == abort_at) begin
        reset = 1'b1;
        rx_read = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rx_read = 1'b0;
        rx = 1'b1;
        model_reset();
        return;
      end
    end
  endtask

  initial begin
    logic [7:0] rd;
    reset = 1'b1; rx = 1'b1; rx_read = 1'b0;
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_all("post_reset");

    // 8N1 0xA5 with exact completion timing.
    send_frame(8'hA5, 1, 0, 0, 0, 0, 0, 1, 0, -1);
    check_all("8n1");
    do_read();
    check_all("8n1_read");

    // 7-bit odd parity, good then bad parity bit.
    send_frame(8'h41, 0, 1, 1, 0, 0, 0, 0, 0, -1);
    check_all("7o1_good");
    do_read();
    send_frame(8'h41, 0, 1, 1, 1, 0, 0, 0, 0, -1);
    check_all("7o1_bad");
    do_read();

    // Framing error, then a normal character right after.
    send_frame(8'h3C, 1, 0, 0, 0, 1, 0, 0, 0, -1);
    check_all("framing");
    do_read();
    send_frame(8'h96, 1, 0, 0, 0, 0, 0, 0, 0, -1);
    check_all("after_framing");
    do_read();

    // Glitch: rx low for only 4 strobes.
    wait_strobe();
    for (int j = 0; j <= 10; j++) begin
      rx = (j < 4) ? 1'b0 : 1'b1;
      wait_strobe();
      if (j == 5) check1("glitch.in_start", rx_idle, 1'b0);
    end
    check_all("glitch");

    // One inverted sample per data bit.
    send_frame(8'h5A, 1, 0, 0, 0, 0, 1, 0, 0, -1);
    check_all("noise");
    do_read();

    // Overflow and read-at-completion.
    send_frame(8'h11, 1, 0, 0, 0, 0, 0, 0, 0, -1);
    send_frame(8'h22, 1, 0, 0, 0, 0, 0, 0, 0, -1);
    check_all("overflow");
    do_read();
    check_all("overflow_read");
    send_frame(8'h44, 1, 0, 0, 0, 0, 0, 0, 0, -1);
    send_frame(8'h55, 1, 0, 0, 0, 0, 0, 0, 0, -1);
    check_all("overflow2");
    send_frame(8'h33, 1, 0, 0, 0, 0, 0, 0, 1, -1);
    check_all("read_at_done");

    // Randomized frames.
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 1) == 1) do_read();
      rd = 8'($urandom);
      send_frame(rd, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), 1'($urandom), 0, 0, -1);
      check_all("random");
    end

    // Reset in the middle of DATA with rx_read in the same cycle.
    send_frame(8'h77, 1, 0, 0, 0, 0, 0, 0, 0, -1);
    send_frame(8'h88, 1, 0, 0, 0, 0, 0, 0, 0, -1);
    send_frame(8'hC3, 1, 1, 0, 0, 0, 0, 0, 0, 40);
    check_all("reset_mid");
    send_frame(8'h6E, 1, 0, 0, 0, 0, 0, 0, 0, -1);
    check_all("after_reset_mid");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_core.md
# uart_rx_core

Serial receive engine for the CoreUARTapb UART, running on the system clock. It consumes the 16x `baud_clock` pulse from the clock generator and recovers framed characters from the `rx` pin: 16x oversampling, a 3-sample majority vote, parity check and stop-bit check. Each received character is presented in a holding register, with error flags, to the APB/FIFO control side.

## Interface
Parameters:
- `GLITCH_REJECT`, default 1: 1 = abort a start bit whose majority vote is 1; 0 = accept any detected falling edge as a start.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `baud_clock`  in  1  one-`clk`-wide 16x oversample strobe
- `rx`  in  1  asynchronous serial input; idles high
- `bit8`  in  1  1 = 8 data bits, 0 = 7 data bits
- `parity_en`  in  1  1 = a parity bit follows the data bits
- `odd_n_even`  in  1  1 = odd parity, 0 = even parity
- `rx_read`  in  1  one-cycle pulse: host has consumed `rx_data`
- `rx_data`  out  8  received character; bit 7 = 0 in 7-bit mode
- `rx_valid`  out  1  `rx_data` holds an unread character
- `parity_err`  out  1  parity mismatch on the held character
- `framing_err`  out  1  stop bit sampled low on the held character
- `overflow`  out  1  sticky: a character arrived while `rx_valid` = 1
- `rx_idle`  out  1  FSM is in IDLE

## Operation
- **Synchronizer:** `rx` passes through 2 flops (reset value 1) to give `rx_s`. All decisions use `rx_s`.
- **State and counter update:** change only on cycles where `baud_clock` = 1. The 4-bit `samp_cnt` increments by 1 on each such cycle and wraps 15 -> 0.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE: when `baud_clock` = 1 and `rx_s` = 0, go to START and set `samp_cnt` = 0.
  - All other states: the samples taken at `samp_cnt` 7, 8 and 9 form the bit value by majority vote (2 of 3). The vote resolves on the `samp_cnt` = 9 strobe.
  - START, at vote: if vote = 1 and `GLITCH_REJECT` = 1, go to IDLE (false start). Otherwise clear `bit_idx` and continue.
  - START -> DATA on the 15 -> 0 wrap.
  - DATA: shift the vote into `shift_reg`, LSB first. Bits per character: 7 (`bit8` = 0) or 8 (`bit8` = 1). After the last bit, on the wrap, go to PARITY if `parity_en` = 1, otherwise to STOP.
  - PARITY: `par_bad` = XOR(data bits, vote, `odd_n_even`), i.e. odd parity is good when the total number of ones is odd. Go to STOP on the wrap.
  - STOP: the vote at `samp_cnt` = 9 completes the character. `framing_err_next` = ~vote. The FSM returns to IDLE on the same strobe, without waiting for the wrap, so the receiver can resync to a start bit that follows a short stop.
- **Character completion:**
  - If `rx_valid` = 0, or `rx_read` = 1 in the same cycle: load `rx_data`, `parity_err` and `framing_err`, and set `rx_valid` = 1.
  - Otherwise: discard the new character, set `overflow` = 1, and leave `rx_data` and its flags unchanged.
- **`rx_read` without completion:**
  - Clears `rx_valid`, `parity_err`, `framing_err` and `overflow`.
  - `rx_data` keeps its value.
  - `rx_read` while `rx_valid` = 0 only clears `overflow`.
- **Configuration:** `bit8`, `parity_en` and `odd_n_even` are sampled continuously. Changing them mid-character is undefined; software changes them only while `rx_idle` = 1.
- **`baud_clock` absent:** the FSM freezes and the flags hold.

## Timing
- **Reset values:** `rx_data` = 0, `rx_valid` = 0, `parity_err` = 0, `framing_err` = 0, `overflow` = 0, `rx_idle` = 1. FSM = IDLE, `samp_cnt` = 0, synchronizer flops = 1.
- **Reset mid-character:** the partial character is dropped and nothing is loaded.
- **Input latency:** `rx` to `rx_s` is 2 `clk` cycles. Start detection then adds up to 1 `baud_clock` period.
- **Output latency:** `rx_valid`, `rx_data` and the error flags update on the `clk` edge after the STOP vote strobe (registered).
- **Character length:** a full character spans (1 + N + P) × 16 + 10 strobes from the detected edge to the STOP vote. N = data bits, P = `parity_en`.
- **Simultaneous events:**
  - `rx_read` and completion in the same cycle: new data loads, `rx_valid` stays 1, `overflow` is cleared (not set).
  - `rx_read` and `reset` in the same cycle: `reset` wins.

## Test plan
- **8N1 receive:** `baud_clock` every 4 clk; send 0xA5 with `bit8` = 1, `parity_en` = 0. Expect `rx_data` = 0xA5, `rx_valid` = 1, both error flags 0, and the `rx_valid` rise exactly 1 clk after the 154th strobe counted from the start edge.
- **7-bit odd parity:** send 0x41 with `bit8` = 0, `odd_n_even` = 1 and a correct parity bit = 1. Expect `rx_data` = 0x41 and `parity_err` = 0. Repeat with parity bit = 0: expect `parity_err` = 1.
- **Framing error:** send 0x3C with the stop bit forced low. Expect `framing_err` = 1 and `rx_data` = 0x3C. The next start bit must still be received correctly.
- **Glitch rejection:** `rx` low for 4 strobes only. Expect a return to IDLE, `rx_valid` = 0, and `rx_idle` = 1 by the 10th strobe.
- **Noise tolerance:** in the DATA state, invert exactly one of the samples at 7/8/9 in every bit of 0x5A. Expect `rx_data` = 0x5A.
- **Overflow:**
  - Receive 0x11 then 0x22 without `rx_read`: expect `rx_data` = 0x11 and `overflow` = 1. A following `rx_read` clears all flags.
  - Then pulse `rx_read` exactly in the completion cycle of 0x33: expect `rx_data` = 0x33, `rx_valid` = 1, `overflow` = 0.
  - Assert `reset` mid-DATA: all outputs return to their reset values on the next clk.
